md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request strobe, sampled on rising edge.
REQ-005 SHALL have port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved, treated as no-op.
REQ-006 SHALL have port rs_data  input  32  multiplicand/dividend/MTHI-MTLO source.
REQ-007 SHALL have port rt_data  input  32  multiplier/divisor.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; pipeline stalls HI/LO readers on it.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port div_by_zero  output  1  one-cycle flag, coincident with done.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 SHALL implement FSM IDLE, CALC, FIX; busy = (state != IDLE).
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, with no queuing.
REQ-016 On accepted MTHI/MTLO: hi/lo <= rs_data at that edge, state stays IDLE, no busy, no done.
REQ-017 On accepted op 0-3 at edge E0: latch magnitudes (abs value for signed ops, raw for unsigned), result signs, op; enter CALC with iteration counter 0.
REQ-018 CALC SHALL perform one radix-2 step per edge, E1..E32 (shift-add multiply / restoring divide, 64-bit working register); after E32 enter FIX.
REQ-019 At E33 (FIX): apply sign correction, write hi/lo, pulse done, return to IDLE. busy is high cycles 0..32, done and new hi/lo are visible in cycle 33; latency 33 cycles for every op 0-3.
REQ-020 Signed multiply: 64-bit product negated when operand signs differ; {hi,lo} = product.
REQ-021 Divide: lo = quotient, hi = remainder; signed quotient negated when signs differ; signed remainder takes dividend sign.
REQ-022 0x80000000 DIV 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no trap).
REQ-023 Divisor zero (DIV/DIVU) SHALL still take 33 cycles, then write hi=rs_data as latched, lo=0xFFFFFFFF, and pulse div_by_zero with done.
REQ-024 flush in CALC or FIX SHALL return to IDLE at the next edge; hi/lo unchanged; no done.
REQ-025 flush and start in the same IDLE cycle: flush wins, start ignored.
REQ-026 flush SHALL have no effect in IDLE.
REQ-027 A new start in the done cycle (state IDLE) SHALL be accepted normally.
REQ-028 Reserved op codes SHALL be accepted as no-ops, with no state change.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, regardless of clk.
REQ-030 Reset mid-operation SHALL discard the operation; no done after release.
REQ-031 The first start SHALL be accepted at the first rising edge with rst_n high.

Verification
REQ-032 MULT rs=0xFFFFFFFD, rt=7 -> busy 33 cycles; cycle 33: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIV -7 (0xFFFFFFF9) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 7/0 -> cycle 33: done=1, div_by_zero=1, hi=7, lo=0xFFFFFFFF; both pulses last exactly one cycle.
REQ-036 MULT started, flush at cycle 10 -> busy=0 cycle 11, hi/lo hold prior values, no done; start during busy ignored; MTLO 0x1234 in IDLE -> lo=0x1234 next cycle, busy stays 0.
REQ-037 rst_n asserted asynchronously at cycle 20 of a DIV -> all outputs zero immediately; no done after release.

Source files
------------

// File: rtl/md_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Every MULT/MULTU/DIV/DIVU takes 33 cycles; MTHI/MTLO write HI/LO in a single edge.
`timescale 1ns/1ps
module md_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int W2 = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v < 0) ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [W2-1:0] neg_wide(input logic [W2-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, dbz_q, dbz_d;

  logic [W2-1:0]       acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   rs_raw_q, rs_raw_d;
  logic                is_div_q, is_div_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;

  logic signed [DATA_W-1:0] rs_s, rt_s;
  logic                     op_signed;
  logic [DATA_W-1:0]        rs_mag, rt_mag;
  logic [DATA_W:0]          mul_sum;
  logic [W2-1:0]            mul_next;
  logic [DATA_W:0]          div_diff;
  logic [W2-1:0]            div_next;

  assign rs_s      = rs_data;
  assign rt_s      = rt_data;
  assign op_signed = ~op[0];
  assign rs_mag    = magnitude(rs_s, op_signed);
  assign rt_mag    = magnitude(rt_s, op_signed);

  // Multiply step: conditionally add multiplicand to the upper half, then shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Restoring divide step: the shifted partial remainder needs DATA_W+1 bits.
  assign div_diff = acc_q[W2-1:DATA_W-1] - {1'b0, opnd_q};
  assign div_next = div_diff[DATA_W] ? {acc_q[W2-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rs_raw_d = rs_raw_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = op[1];
              acc_d    = {{DATA_W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
              opnd_d   = op[1] ? rt_mag : rs_mag;
              rs_raw_d = rs_data;
              qneg_d   = op_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
              rneg_d   = op_signed & rs_data[DATA_W-1];
              dz_d     = (rt_data == '0);
              cnt_d    = 5'd0;
              state_d  = S_CALC;
            end
            OP_MTHI: hi_d = rs_data;
            OP_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_wide(acc_q, qneg_q);
          end else if (dz_q) begin
            hi_d  = rs_raw_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_word(acc_q[DATA_W-1:0], qneg_q);
            hi_d = neg_word(acc_q[W2-1:DATA_W], rneg_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    rs_raw_q <= rs_raw_d;
    is_div_q <= is_div_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    dz_q     <= dz_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
